// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_arbiter
//  Purpose  : Two-requester arbiter for the shared CPU system bus. Port 0 is
//             the instruction-fetch sub-interface and port 1 is the
//             data-memory sub-interface. One port is granted per transaction.
//             The granted port's address, data and control are muxed onto
//             the bus, and the slave ack is returned to that port only. A
//             watchdog aborts any transaction whose strobe is not acked
//             within TIMEOUT cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RR_MODE  0 = fixed priority (port 1 wins ties),
//             1 = round-robin (port not served last wins ties)
//    TIMEOUT  strobe cycles without ack before abort (2..65535)
//    CNT_W    watchdog counter width, 2**CNT_W > TIMEOUT
//  Ports
//    clk_i, rst_n_i          clock, synchronous active-low reset
//    mX_req_i / mX_stb_i     request / strobe from port X
//    mX_we_i / mX_adr_i      write enable / address from port X
//    mX_dat_i / mX_sel_i     write data / byte selects from port X
//    mX_ack_o / mX_err_o     per-port ack / one-cycle timeout abort
//    m_dat_o                 read data broadcast to both ports
//    bus_*_o / bus_*_i       shared system bus master side
//    grant_o                 one-hot grant (bit0 port 0, bit1 port 1)
//    timeout_o               sticky abort flag, cleared only by reset
// ============================================================================
module cpu_bus_arbiter #(
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // port 0 : instruction fetch
  input  logic        m0_req_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // port 1 : data memory
  input  logic        m1_req_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared read data
  output logic [31:0] m_dat_o,
  // system bus
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_dat_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT0 = 2'd1;
  localparam logic [1:0] S_GNT1 = 2'd2;

  // Count value at which a still-unacked strobe is aborted.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last;        // last served port: 0 = port 0, 1 = port 1
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_granted;
  logic             w_req;         // request of the currently granted port
  logic             w_stb;         // strobe of the currently granted port
  logic             w_wait;        // strobe outstanding without ack this cycle
  logic             w_tmo;         // watchdog abort this cycle
  logic             w_tie_pick1;   // tie-break choice when both ports request

  assign w_gnt0    = (r_state == S_GNT0);
  assign w_gnt1    = (r_state == S_GNT1);
  assign w_granted = w_gnt0 | w_gnt1;

  // Fixed priority always hands ties to the data port; round-robin hands
  // them to whichever port was not served last.
  assign w_tie_pick1 = (RR_MODE == 0) ? 1'b1 : ~r_last;

  // --------------------------------------------------------------------------
  // Bus mux: the granted port drives the bus, idle drives zeros.
  // --------------------------------------------------------------------------
  always_comb begin
    w_req     = 1'b0;
    w_stb     = 1'b0;
    bus_we_o  = 1'b0;
    bus_adr_o = 32'h0;
    bus_dat_o = 32'h0;
    bus_sel_o = 4'h0;
    if (w_gnt0) begin
      w_req     = m0_req_i;
      w_stb     = m0_stb_i;
      bus_we_o  = m0_we_i;
      bus_adr_o = m0_adr_i;
      bus_dat_o = m0_dat_i;
      bus_sel_o = m0_sel_i;
    end else if (w_gnt1) begin
      w_req     = m1_req_i;
      w_stb     = m1_stb_i;
      bus_we_o  = m1_we_i;
      bus_adr_o = m1_adr_i;
      bus_dat_o = m1_dat_i;
      bus_sel_o = m1_sel_i;
    end
  end

  assign bus_cyc_o = w_granted;
  assign bus_stb_o = w_stb;

  // An ack in the abort cycle still completes the transfer, so the abort
  // condition requires the ack to be absent.
  assign w_wait = w_granted & w_stb & ~bus_ack_i;
  assign w_tmo  = w_wait & (r_cnt == C_CNT_LAST);

  // Ack only reaches the port that owns the bus.
  assign m0_ack_o = w_gnt0 & bus_ack_i;
  assign m1_ack_o = w_gnt1 & bus_ack_i;
  assign m0_err_o = w_gnt0 & w_tmo;
  assign m1_err_o = w_gnt1 & w_tmo;
  assign m_dat_o  = bus_dat_i;

  assign grant_o   = {w_gnt1, w_gnt0};
  assign timeout_o = r_timeout;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (m0_req_i && m1_req_i) begin
          w_state_nxt = w_tie_pick1 ? S_GNT1 : S_GNT0;
        end else if (m1_req_i) begin
          w_state_nxt = S_GNT1;
        end else if (m0_req_i) begin
          w_state_nxt = S_GNT0;
        end
      end
      S_GNT0, S_GNT1: begin
        // Completion and abort both count as having served this port;
        // a withdrawn request does not.
        if (bus_ack_i || w_tmo) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = w_gnt1;
        end else if (!w_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Watchdog: held at zero while idle so every grant starts from zero, then
  // counts unacked strobe cycles and saturates rather than wrapping.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!w_granted) begin
      w_cnt_nxt = '0;
    end else if (w_wait && (r_cnt != C_CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_bus_arbiter
//  Purpose  : Directed self-checking bench for cpu_bus_arbiter. Two
//             instances share all stimulus: u_a (fixed priority, TIMEOUT=4)
//             and u_b (round-robin, TIMEOUT=255).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_stb, m0_we, m1_req, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        bus_ack;
  logic [31:0] bus_dat;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_cyc, a_stb, a_we, a_tmo;
  logic [31:0] a_mdat, a_adr, a_dat;
  logic [3:0]  a_sel;
  logic [1:0]  a_gnt;

  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_cyc, b_stb, b_we, b_tmo;
  logic [31:0] b_mdat, b_adr, b_dat;
  logic [3:0]  b_sel;
  logic [1:0]  b_gnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.RR_MODE(0), .TIMEOUT(4), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_req_i(m1_req), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .m_dat_o(a_mdat), .bus_cyc_o(a_cyc), .bus_stb_o(a_stb), .bus_we_o(a_we),
    .bus_adr_o(a_adr), .bus_dat_o(a_dat), .bus_sel_o(a_sel),
    .bus_ack_i(bus_ack), .bus_dat_i(bus_dat), .grant_o(a_gnt), .timeout_o(a_tmo)
  );

  cpu_bus_arbiter #(.RR_MODE(1), .TIMEOUT(255), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_req_i(m1_req), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .m_dat_o(b_mdat), .bus_cyc_o(b_cyc), .bus_stb_o(b_stb), .bus_we_o(b_we),
    .bus_adr_o(b_adr), .bus_dat_o(b_dat), .bus_sel_o(b_sel),
    .bus_ack_i(bus_ack), .bus_dat_i(bus_dat), .grant_o(b_gnt), .timeout_o(b_tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    m0_req = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 32'h0; m0_dat = 32'h0; m0_sel = 4'h0;
    m1_req = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 32'h0; m1_dat = 32'h0; m1_sel = 4'h0;
    bus_ack = 1'b0; bus_dat = 32'h0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_a_gnt", 32'(a_gnt), 32'h0);
    check("rst_a_cyc", 32'(a_cyc), 32'h0);
    check("rst_a_stb", 32'(a_stb), 32'h0);
    check("rst_a_tmo", 32'(a_tmo), 32'h0);
    check("rst_b_gnt", 32'(b_gnt), 32'h0);
    check("rst_b_acks", 32'({b_m0_ack, b_m1_ack, b_m0_err, b_m1_err}), 32'h0);
    rst_n = 1'b1;

    // ---------------- port 0 alone, ack 3 cycles after grant ----------------
    m0_req = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0040_0000; m0_sel = 4'hF;
    #1;
    check("t1_pre_gnt", 32'(b_gnt), 32'h0);
    step();
    check("t1_gnt", 32'(b_gnt), 32'h1);
    check("t1_cyc", 32'(b_cyc), 32'h1);
    check("t1_adr", b_adr, 32'h0040_0000);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus_ack = 1'b1;
        bus_dat = 32'hDEAD_BEEF;
      end
      #1;
      check("t1_m0_ack", 32'(b_m0_ack), 32'(k == 3));
      check("t1_m1_ack", 32'(b_m1_ack), 32'h0);
      if (k == 3) check("t1_mdat", b_mdat, 32'hDEAD_BEEF);
      step();
    end
    m0_req = 1'b0; m0_stb = 1'b0; bus_ack = 1'b0;
    #1;
    check("t1_idle_gnt", 32'(b_gnt), 32'h0);
    check("t1_idle_cyc", 32'(b_cyc), 32'h0);

    // ---------------- ack on the same cycle the count reaches 3 ----------------
    m1_req = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h2000_0010; m1_sel = 4'hF;
    step();
    check("t5_gnt", 32'(a_gnt), 32'h2);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus_ack = 1'b1;
      #1;
      check("t5_m1_err", 32'(a_m1_err), 32'h0);
      if (k == 3) check("t5_m1_ack", 32'(a_m1_ack), 32'h1);
      step();
    end
    m1_req = 1'b0; m1_stb = 1'b0; bus_ack = 1'b0;
    #1;
    check("t5_tmo", 32'(a_tmo), 32'h0);
    check("t5_idle_gnt", 32'(a_gnt), 32'h0);

    // ---------------- port 1 write, no ack, watchdog abort ----------------
    m1_req = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr = 32'h1000_0004; m1_dat = 32'h1234_5678; m1_sel = 4'hF;
    step();
    check("t4_gnt", 32'(a_gnt), 32'h2);
    check("t4_we", 32'(a_we), 32'h1);
    check("t4_adr", a_adr, 32'h1000_0004);
    check("t4_dat", a_dat, 32'h1234_5678);
    check("t4_sel", 32'(a_sel), 32'hF);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4_m1_err", 32'(a_m1_err), 32'(k == 3));
      check("t4_tmo_pre", 32'(a_tmo), 32'h0);
      step();
    end
    check("t4_cyc_drop", 32'(a_cyc), 32'h0);
    check("t4_tmo_set", 32'(a_tmo), 32'h1);
    m1_req = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
    check("t4_tmo_sticky", 32'(a_tmo), 32'h1);
    check("t4_b_withdraw", 32'(b_gnt), 32'h0);
    check("t4_b_tmo", 32'(b_tmo), 32'h0);
    // a later port 0 transaction completes normally
    m0_req = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0040_0008;
    step();
    check("t4_p0_gnt", 32'(a_gnt), 32'h1);
    bus_ack = 1'b1;
    #1;
    check("t4_p0_ack", 32'(a_m0_ack), 32'h1);
    check("t4_p0_err", 32'(a_m0_err), 32'h0);
    step();
    m0_req = 1'b0; m0_stb = 1'b0; bus_ack = 1'b0;
    #1;
    check("t4_p0_idle", 32'(a_gnt), 32'h0);
    check("t4_tmo_hold", 32'(a_tmo), 32'h1);

    // ------- both ports request continuously, slave acks immediately -------
    // u_b last served port 0, so its round-robin sequence starts with port 1.
    m0_req = 1'b1; m0_stb = 1'b1; m1_req = 1'b1; m1_stb = 1'b1; bus_ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t2_fixed_gnt", 32'(a_gnt), (i % 2 == 1) ? 32'h2 : 32'h0);
      check("t2_fixed_m0_ack", 32'(a_m0_ack), 32'h0);
      check("t3_rr_gnt", 32'(b_gnt), (i % 4 == 1) ? 32'h2 : ((i % 4 == 3) ? 32'h1 : 32'h0));
    end
    m0_req = 1'b0; m0_stb = 1'b0; m1_req = 1'b0; m1_stb = 1'b0; bus_ack = 1'b0;
    step();

    // ---------------- reset while GNT0 waits for ack ----------------
    m0_req = 1'b1; m0_stb = 1'b1;
    step();
    check("t6_gnt", 32'(a_gnt), 32'h1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; m0_req = 1'b0; m0_stb = 1'b0;
    #1;
    check("t6_gnt_rst", 32'(a_gnt), 32'h0);
    check("t6_cyc_rst", 32'(a_cyc), 32'h0);
    check("t6_tmo_clr", 32'(a_tmo), 32'h0);
    bus_ack = 1'b1;
    #1;
    check("t6_late_ack", 32'({a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack}), 32'h0);
    step();
    check("t6_late_ack2", 32'({a_m0_ack, a_m1_ack}), 32'h0);
    bus_ack = 1'b0;

    // ---------------- tie-break right after reset ----------------
    m0_req = 1'b1; m0_stb = 1'b1; m1_req = 1'b1; m1_stb = 1'b1;
    step();
    check("rst_rr_tie", 32'(b_gnt), 32'h1);
    check("rst_fixed_tie", 32'(a_gnt), 32'h2);
    m0_req = 1'b0; m0_stb = 1'b0; m1_req = 1'b0; m1_stb = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
